// File: rtl/coreriscv_axi4_rr_arbiter_pkg.sv
// Shared constants and helpers for the L1 data-array request arbiter.
package coreriscv_axi4_rr_arbiter_pkg;

  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;

  localparam int DEF_N_IN   = 4;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_WAY_W  = 1;

  // Index width for n requesters; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/coreriscv_axi4_rr_arbiter_chk.sv
// Protocol properties of the arbiter output and requester grants.
module coreriscv_axi4_rr_arbiter_chk #(
  parameter int N_IN  = 4,
  parameter int PAY_W = 8
) (
  input logic             clk,
  input logic             reset,
  input logic [N_IN-1:0]  in_ready,
  input logic             out_valid,
  input logic             out_ready,
  input logic [PAY_W-1:0] out_payload
);

  a_ready_onehot0: assert property (@(posedge clk) disable iff (!reset) $onehot0(in_ready));

  a_out_stable: assert property (@(posedge clk) disable iff (!reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_payload)));

endmodule

// File: rtl/coreriscv_axi4_skid_buf.sv
// Two-entry valid/ready skid buffer; in_ready comes straight from a flop.
module coreriscv_axi4_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [1:0]       count_r;
  logic [1:0]       count_nxt_s;
  logic             full_r;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic             push_s;
  logic             pop_s;

  assign in_ready  = ~full_r;
  assign out_valid = (count_r != 2'd0);
  assign out_data  = head_r;
  assign push_s    = in_valid & ~full_r;
  assign pop_s     = out_valid & out_ready;

  // Occupancy after this cycle's push and pop.
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + 2'd1;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - 2'd1;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // head_r always holds the oldest entry, so it keeps the last beat once drained.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= 2'd0;
      full_r  <= 1'b0;
      head_r  <= '0;
      tail_r  <= '0;
    end else begin
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == 2'd2);
      case (count_r)
        2'd0: if (push_s) head_r <= in_data;
        2'd1: begin
          if (push_s && pop_s) head_r <= in_data;
          else if (push_s)     tail_r <= in_data;
        end
        2'd2: if (pop_s) head_r <= tail_r;
        default: head_r <= head_r;
      endcase
    end
  end

endmodule

// File: rtl/coreriscv_axi4_rr_arbiter.sv
// N-way data-array request arbiter: fixed-priority or round-robin select, grant
// hold while stalled, optional skid stage on the output.
module coreriscv_axi4_rr_arbiter
  import coreriscv_axi4_rr_arbiter_pkg::*;
#(
  parameter int N_IN    = DEF_N_IN,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int WAY_W   = DEF_WAY_W,
  parameter int MODE    = ARB_MODE_FIXED,
  parameter int OUT_REG = 0,
  localparam int MASK_W = DATA_W / 8,
  localparam int IDX_W  = clog2_min1(N_IN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_IN-1:0]          in_valid,
  output logic [N_IN-1:0]          in_ready,
  input  logic [N_IN*ADDR_W-1:0]   in_addr,
  input  logic [N_IN-1:0]          in_write,
  input  logic [N_IN*DATA_W-1:0]   in_wdata,
  input  logic [N_IN*MASK_W-1:0]   in_wmask,
  input  logic [N_IN*WAY_W-1:0]    in_way_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     out_write,
  output logic [DATA_W-1:0]        out_wdata,
  output logic [MASK_W-1:0]        out_wmask,
  output logic [WAY_W-1:0]         out_way_en,
  output logic [IDX_W-1:0]         out_chosen
);

  localparam int DAT_W = ADDR_W + 1 + DATA_W + MASK_W + WAY_W;
  localparam int PAY_W = DAT_W + IDX_W;

  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] hold_idx_r;
  logic             hold_vld_r;
  logic [IDX_W-1:0] base_s;
  logic [IDX_W-1:0] win_idx_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic [IDX_W:0]   cand_s;
  logic             win_found_s;
  logic             held_live_s;
  logic             sel_valid_s;
  logic             stage_ready_s;
  logic             handshake_s;
  logic [DAT_W-1:0] sel_dat_s;
  logic [PAY_W-1:0] out_pay_s;

  // Find-first valid requester walking upward from the base index, modulo N_IN.
  always_comb begin
    base_s      = (MODE == ARB_MODE_RR) ? rr_ptr_r : '0;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < N_IN; k++) begin
      cand_s      = {1'b0, base_s} + (IDX_W+1)'(k);
      cand_s      = (cand_s >= (IDX_W+1)'(N_IN)) ? (cand_s - (IDX_W+1)'(N_IN)) : cand_s;
      win_idx_s   = (!win_found_s && in_valid[cand_s[IDX_W-1:0]]) ? cand_s[IDX_W-1:0] : win_idx_s;
      win_found_s = win_found_s | in_valid[cand_s[IDX_W-1:0]];
    end
  end

  // A held grant that loses its valid falls back to fresh arbitration this cycle.
  assign held_live_s = hold_vld_r & in_valid[hold_idx_r];
  assign sel_valid_s = held_live_s | win_found_s;
  assign sel_idx_s   = held_live_s ? hold_idx_r : win_idx_s;
  assign handshake_s = sel_valid_s & stage_ready_s;

  always_comb begin
    in_ready = '0;
    if (handshake_s) begin
      in_ready[sel_idx_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  assign sel_dat_s = {in_addr[int'(sel_idx_s)*ADDR_W +: ADDR_W],
                      in_write[sel_idx_s],
                      in_wdata[int'(sel_idx_s)*DATA_W +: DATA_W],
                      in_wmask[int'(sel_idx_s)*MASK_W +: MASK_W],
                      in_way_en[int'(sel_idx_s)*WAY_W +: WAY_W]};

  // Round-robin pointer and stalled-grant hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_r   <= '0;
      hold_vld_r <= 1'b0;
      hold_idx_r <= '0;
    end else begin
      hold_vld_r <= sel_valid_s & ~stage_ready_s;
      hold_idx_r <= sel_idx_s;
      if ((MODE == ARB_MODE_RR) && handshake_s) begin
        rr_ptr_r <= (sel_idx_s == IDX_W'(N_IN - 1)) ? '0 : (sel_idx_s + IDX_W'(1));
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_skid
      logic skid_ready_s;
      logic skid_valid_s;

      coreriscv_axi4_skid_buf #(.WIDTH(PAY_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (sel_valid_s),
        .in_ready  (skid_ready_s),
        .in_data   ({sel_dat_s, sel_idx_s}),
        .out_valid (skid_valid_s),
        .out_ready (out_ready),
        .out_data  (out_pay_s)
      );

      assign stage_ready_s = skid_ready_s & reset;
      assign out_valid     = skid_valid_s & reset;
    end else begin : g_comb
      logic [IDX_W-1:0] chosen_last_r;

      // Remember the last forwarded index so out_chosen is steady while idle.
      always_ff @(posedge clk) begin
        if (!reset) begin
          chosen_last_r <= '0;
        end else if (sel_valid_s) begin
          chosen_last_r <= sel_idx_s;
        end
      end

      assign stage_ready_s = out_ready & reset;
      assign out_valid     = sel_valid_s & reset;
      assign out_pay_s     = {sel_dat_s, (sel_valid_s ? sel_idx_s : chosen_last_r)};
    end
  endgenerate

  assign {out_addr, out_write, out_wdata, out_wmask, out_way_en} = out_pay_s[PAY_W-1:IDX_W];
  assign out_chosen = reset ? out_pay_s[IDX_W-1:0] : '0;

  coreriscv_axi4_rr_arbiter_chk #(.N_IN(N_IN), .PAY_W(PAY_W)) u_chk (
    .clk         (clk),
    .reset       (reset),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload ({out_addr, out_write, out_wdata, out_wmask, out_way_en, out_chosen})
  );

endmodule
